// File: rtl/reg_xfer_seq_pkg.sv
// Shared types for the register-transfer sequencer: command opcodes, FSM states, latched command.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg_xfer_seq_pkg;

   localparam int unsigned IDX_W = 4;
   localparam int unsigned NREG  = 16;

   typedef enum logic [1:0] {
      OP_MOV  = 2'b00,
      OP_SWAP = 2'b01,
      OP_CLR  = 2'b10,
      OP_RSV  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_T1   = 3'd1,
      ST_T2   = 3'd2,
      ST_T3   = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   typedef struct packed {
      op_e              op;
      logic [IDX_W-1:0] ra;
      logic [IDX_W-1:0] rb;
   } cmd_t;

endpackage

// File: rtl/dec4to16.sv
// 4-to-16 one-hot decoder with enable; used for register load and bus-drive selects.
// Latency: combinational.
// Backpressure: none.
module dec4to16 (
   input  logic [3:0]  idx_i,
   input  logic        en_i,
   output logic [15:0] onehot_o
);

   // drive exactly one bit when enabled, nothing otherwise
   always_comb begin
      onehot_o = '0;
      if (en_i) begin
         onehot_o[idx_i] = 1'b1;
      end
   end

endmodule

// File: rtl/reg_xfer_seq.sv
// Control sequencer for a single-bus register file: MOV, SWAP (through temp Y) and CLR.
// Latency: start accepted at edge N -> done at N+2 (MOV/CLR), N+4 (SWAP), N+1 (reserved, with err).
// Backpressure: busy is high outside IDLE; start is ignored until the FSM is back in IDLE.
module reg_xfer_seq
   import reg_xfer_seq_pkg::*;
(
   input  logic        clk,
   input  logic        clr_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [3:0]  ra,
   input  logic [3:0]  rb,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] Rin,
   output logic [15:0] Rout,
   output logic        BAout,
   output logic        Yin,
   output logic        Yout
);

   state_e           state_q;
   state_e           state_d;
   cmd_t             cmd_q;
   logic             accept;

   logic             rin_en;
   logic [IDX_W-1:0] rin_idx;
   logic             rout_en;
   logic [IDX_W-1:0] rout_idx;

   // a command is only taken while idle; everything else ignores start
   assign accept = (state_q == ST_IDLE) && start;

   // state register, reset asynchronously back to IDLE
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // latch the command fields at accept so later input changes cannot disturb it
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         cmd_q <= '0;
      end else if (accept) begin
         cmd_q.op <= op_e'(op);
         cmd_q.ra <= ra;
         cmd_q.rb <= rb;
      end
   end

   // next-state: only SWAP walks through T2/T3, reserved op skips straight to DONE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = (op_e'(op) == OP_RSV) ? ST_DONE : ST_T1;
            end
         end
         ST_T1:   state_d = (cmd_q.op == OP_SWAP) ? ST_T2 : ST_DONE;
         ST_T2:   state_d = ST_T3;
         ST_T3:   state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // output decode from registered state and latched fields only
   always_comb begin
      busy     = (state_q != ST_IDLE);
      done     = 1'b0;
      err      = 1'b0;
      BAout    = 1'b0;
      Yin      = 1'b0;
      Yout     = 1'b0;
      rin_en   = 1'b0;
      rin_idx  = '0;
      rout_en  = 1'b0;
      rout_idx = '0;
      unique case (state_q)
         ST_T1: begin
            unique case (cmd_q.op)
               OP_MOV: begin
                  rout_en  = 1'b1;
                  rout_idx = cmd_q.rb;
                  rin_en   = 1'b1;
                  rin_idx  = cmd_q.ra;
               end
               OP_SWAP: begin
                  // park Ra in Y before it gets overwritten in T2
                  rout_en  = 1'b1;
                  rout_idx = cmd_q.ra;
                  Yin      = 1'b1;
               end
               OP_CLR: begin
                  // R0 drives the bus but BAout forces its value to zero
                  rout_en  = 1'b1;
                  rout_idx = '0;
                  BAout    = 1'b1;
                  rin_en   = 1'b1;
                  rin_idx  = cmd_q.ra;
               end
               default: ;
            endcase
         end
         ST_T2: begin
            rout_en  = 1'b1;
            rout_idx = cmd_q.rb;
            rin_en   = 1'b1;
            rin_idx  = cmd_q.ra;
         end
         ST_T3: begin
            Yout    = 1'b1;
            rin_en  = 1'b1;
            rin_idx = cmd_q.rb;
         end
         ST_DONE: begin
            done = 1'b1;
            err  = (cmd_q.op == OP_RSV);
         end
         default: ;
      endcase
   end

   dec4to16 u_dec_rin (
      .idx_i    (rin_idx),
      .en_i     (rin_en),
      .onehot_o (Rin)
   );

   dec4to16 u_dec_rout (
      .idx_i    (rout_idx),
      .en_i     (rout_en),
      .onehot_o (Rout)
   );

endmodule

// File: tb/tb_reg_xfer_seq.sv
// Scoreboard bench for reg_xfer_seq: expected per-cycle strobes queued at accept, register-file effect modelled.
// Latency: monitor samples 1 time unit after each rising edge.
// Backpressure: driver only issues a command when its own model says the sequencer is idle.
module tb_reg_xfer_seq;

   typedef struct packed {
      logic        busy;
      logic        done;
      logic        err;
      logic        ba;
      logic        yin;
      logic        yout;
      logic [15:0] rin;
      logic [15:0] rout;
   } vec_t;

   typedef struct {
      vec_t v;
      int   cyc;
   } exp_t;

   typedef struct {
      logic [1:0] op;
      logic [3:0] a;
      logic [3:0] b;
   } cmd_t;

   logic        clk = 1'b0;
   logic        clr_n;
   logic        start;
   logic [1:0]  op;
   logic [3:0]  ra;
   logic [3:0]  rb;
   logic        busy, done, err, BAout, Yin, Yout;
   logic [15:0] Rin, Rout;

   exp_t        expq[$];
   cmd_t        cmdq[$];
   logic [15:0] dp[16];
   logic [15:0] gold[16];
   logic [15:0] ybuf;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          rem = 0;

   reg_xfer_seq dut (
      .clk   (clk),
      .clr_n (clr_n),
      .start (start),
      .op    (op),
      .ra    (ra),
      .rb    (rb),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .Rin   (Rin),
      .Rout  (Rout),
      .BAout (BAout),
      .Yin   (Yin),
      .Yout  (Yout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic vec_t sample();
      return vec_t'({busy, done, err, BAout, Yin, Yout, Rin, Rout});
   endfunction

   function automatic vec_t mk(input logic [15:0] rin_v, input logic [15:0] rout_v,
                               input bit ba_v, input bit yin_v, input bit yout_v,
                               input bit done_v, input bit err_v);
      vec_t v;
      v.busy = 1'b1;
      v.done = done_v;
      v.err  = err_v;
      v.ba   = ba_v;
      v.yin  = yin_v;
      v.yout = yout_v;
      v.rin  = rin_v;
      v.rout = rout_v;
      return v;
   endfunction

   // expected strobe sequence of one command, one entry per busy cycle
   task automatic push_cmd(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
      vec_t        steps[$];
      logic [15:0] ha, hb;
      exp_t        e;
      cmd_t        c;
      ha = 16'h0001 << a;
      hb = 16'h0001 << b;
      case (o)
         2'b00: steps.push_back(mk(ha, hb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
         2'b01: begin
            steps.push_back(mk(16'h0, ha, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
            steps.push_back(mk(ha, hb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            steps.push_back(mk(hb, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
         end
         2'b10: steps.push_back(mk(ha, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
         default: ;
      endcase
      steps.push_back(mk(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, o == 2'b11));
      foreach (steps[i]) begin
         e.v   = steps[i];
         e.cyc = cyc + 1 + i;
         expq.push_back(e);
      end
      c.op = o;
      c.a  = a;
      c.b  = b;
      cmdq.push_back(c);
      rem = steps.size();
   endtask

   // drive one cycle of inputs at a falling edge; only an idle model accepts start
   task automatic drive(input bit st, input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
      start = st;
      op    = o;
      ra    = a;
      rb    = b;
      if (rem == 0 && st) begin
         push_cmd(o, a, b);
      end else if (rem > 0) begin
         rem--;
      end
      @(negedge clk);
   endtask

   task automatic drive_noise();
      drive(1'($urandom_range(1)), 2'($urandom_range(3)), 4'($urandom_range(15)), 4'($urandom_range(15)));
   endtask

   // issue a command, scramble inputs while busy, then leave a random idle gap
   task automatic issue(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
      int gap;
      drive(1'b1, o, a, b);
      while (rem > 0) drive_noise();
      gap = $urandom_range(2);
      repeat (gap) drive(1'b0, 2'($urandom_range(3)), 4'($urandom_range(15)), 4'($urandom_range(15)));
   endtask

   // monitor: compare strobes, replay them on a register-file model, check results at done
   always @(posedge clk) begin
      vec_t        s;
      exp_t        e;
      cmd_t        c;
      logic [15:0] bus;
      logic [15:0] t;
      int          idx;
      bit          ok;
      #1;
      if (clr_n === 1'b1) begin
         s = sample();
         check("one_bus_driver", 64'(($countones(Rout) + int'(Yout)) <= 1), 64'd1);
         check("one_rin", 64'($countones(Rin) <= 1), 64'd1);
         if (s.busy !== 1'b1) begin
            check("idle_out", 64'(s), 64'd0);
         end else if (expq.size() == 0) begin
            check("unexpected_busy", 64'(s), 64'd0);
         end else begin
            e = expq.pop_front();
            check("strobes", 64'(s), 64'(e.v));
            check("cycle", 64'(cyc), 64'(e.cyc));
            bus = 16'h0;
            idx = 0;
            for (int i = 0; i < 16; i++) if (s.rout[i]) idx = i;
            if (s.yout) bus = ybuf;
            else if (s.rout != 16'h0) bus = (s.ba && idx == 0) ? 16'h0 : dp[idx];
            for (int i = 0; i < 16; i++) if (s.rin[i]) dp[i] = bus;
            if (s.yin) ybuf = bus;
            if (s.done && cmdq.size() > 0) begin
               c = cmdq.pop_front();
               case (c.op)
                  2'b00: gold[c.a] = gold[c.b];
                  2'b01: begin
                     t = gold[c.a];
                     gold[c.a] = gold[c.b];
                     gold[c.b] = t;
                  end
                  2'b10: gold[c.a] = 16'h0;
                  default: ;
               endcase
               ok = 1'b1;
               for (int i = 0; i < 16; i++) if (dp[i] !== gold[i]) ok = 1'b0;
               check("regfile", 64'(ok), 64'd1);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      clr_n = 1'b0;
      start = 1'b0;
      op    = 2'b00;
      ra    = 4'd0;
      rb    = 4'd0;
      ybuf  = 16'h0;
      for (int i = 0; i < 16; i++) begin
         dp[i]   = 16'($urandom);
         gold[i] = dp[i];
      end
      repeat (3) @(negedge clk);
      check("reset_out", 64'(sample()), 64'd0);
      clr_n = 1'b1;

      // directed commands, including ra==rb and CLR of R0
      issue(2'b00, 4'd3, 4'd7);
      issue(2'b01, 4'd2, 4'd5);
      issue(2'b10, 4'd0, 4'd9);
      issue(2'b11, 4'd6, 4'd1);
      issue(2'b01, 4'd3, 4'd3);
      issue(2'b00, 4'd9, 4'd9);
      issue(2'b10, 4'd5, 4'd5);
      issue(2'b10, 4'd15, 4'd0);

      // reset pulsed during SWAP T2, then a MOV on the first edge after release
      drive(1'b1, 2'b01, 4'd4, 4'd9);
      drive(1'b0, 2'b01, 4'd4, 4'd9);
      #2 clr_n = 1'b0;
      #1 check("async_reset_out", 64'(sample()), 64'd0);
      @(negedge clk);
      check("reset_hold_out", 64'(sample()), 64'd0);
      @(negedge clk);
      clr_n = 1'b1;
      expq.delete();
      cmdq.delete();
      gold = dp;
      rem  = 0;
      issue(2'b00, 4'd10, 4'd11);

      // start held high: one SWAP per IDLE visit
      repeat (22) drive(1'b1, 2'b01, 4'd1, 4'd6);
      while (rem > 0) drive(1'b0, 2'b00, 4'd0, 4'd0);
      drive(1'b0, 2'b00, 4'd0, 4'd0);

      // random traffic
      repeat (250) issue(2'($urandom_range(3)), 4'($urandom_range(15)), 4'($urandom_range(15)));

      repeat (3) drive(1'b0, 2'b00, 4'd0, 4'd0);
      check("queue_drained", 64'(expq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
